// File: rtl/fetch_pc_sel.sv
// Fetch-stage PC select and F-register with next-PC prediction.
// Optional return-address stack is enabled by defining FETCH_RAS_EN.
module fetch_pc_sel #(
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_stall,
  input  logic [3:0]  icode_f,
  input  logic [63:0] valc_f,
  input  logic [63:0] valp_f,
  input  logic [3:0]  m_icode,
  input  logic        m_cnd,
  input  logic [63:0] m_vala,
  input  logic        w_ret_redirect,
  input  logic [63:0] w_valm,
  output logic [63:0] pc_f,
  output logic [63:0] pc_predicted_f,
  output logic        ret_predicted
);

  localparam logic [3:0] IJXX  = 4'd7;
  localparam logic [3:0] ICALL = 4'd8;
  localparam logic [3:0] IRET  = 4'd9;

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("fetch_pc_sel: RAS_DEPTH must be a power of two >= 2");
  end

  logic        ras_hit;
  logic [63:0] ras_top_val;
  logic [63:0] next_pred;

`ifdef FETCH_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [63:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] top_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] top_prev;
  logic          push;
  logic          pop;

  // top_r points at the next free slot; the live top entry sits just below it
  assign top_prev    = top_r - PW'(1);
  assign ras_hit     = (icode_f == IRET) && (count_r != {CW{1'b0}});
  assign ras_top_val = ras_mem[top_prev];
  assign push        = !f_stall && (icode_f == ICALL);
  assign pop         = !f_stall && ras_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_r   <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (push) begin
      top_r <= top_r + PW'(1);
      if (count_r != CW'(RAS_DEPTH)) begin
        count_r <= count_r + CW'(1);
      end
    end else if (pop) begin
      top_r   <= top_prev;
      count_r <= count_r - CW'(1);
    end
  end

  // Entries need no reset: they are only read while count_r covers them
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[top_r] <= valp_f;
    end
  end
`else
  assign ras_hit     = 1'b0;
  assign ras_top_val = 64'd0;
`endif

  assign ret_predicted = ras_hit;

  always_comb begin
    if (m_icode == IJXX && !m_cnd) begin
      pc_f = m_vala;
    end else if (w_ret_redirect) begin
      pc_f = w_valm;
    end else begin
      pc_f = pc_predicted_f;
    end
  end

  always_comb begin
    next_pred = valp_f;
    case (icode_f)
      IJXX, ICALL: next_pred = valc_f;
      IRET: begin
        if (ras_hit) begin
          next_pred = ras_top_val;
        end else begin
          next_pred = valp_f;
        end
      end
      default: next_pred = valp_f;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_predicted_f <= 64'd0;
    end else if (!f_stall) begin
      pc_predicted_f <= next_pred;
    end
  end

endmodule
